vending_arbiter: RTL and testbench

- Shares one vending machine (coin-in, change-out, beverage, enable interface) among N customer coin slots.
- Grants the machine to one slot for a whole transaction, picking requesters round-robin.
- Forwards the granted slot's coins to the machine and routes the machine's change and beverage back to that slot only.
- Releases the grant on transaction completion, on abandonment before any coin, or on an idle timeout.

---
 rtl/vending_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_vending_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vending_arbiter.sv
// -----------------------------------------------------------------------------
// vending_arbiter
//
// Lets N customer coin slots share one vending machine. One slot is granted for
// a whole transaction, chosen round-robin among the requesting slots. While a
// slot holds the grant, its coins go to the machine through a registered
// deposit. The machine's change and beverage signals are routed back to that
// slot only.
//
// The grant is released in three cases:
//   - the transaction completes (SETTLE -> DONE -> IDLE),
//   - the customer drops req before inserting any coin (ARMED -> IDLE),
//   - the customer stays idle in PAID for TIMEOUT cycles. This release raises
//     a one-cycle abandon pulse.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   req[N]         per-slot request; held high while the slot wants the machine
//   coin_in[2N]    per-slot coin, slot i at [2i+1:2i]
//                  (0 none, 1 nickel, 2 dime, 3 quarter)
//   vend_enable    machine accepts coins
//   vend_beverage  machine dispensing
//   vend_change[2] machine change coin
//   deposit[2]     registered coin forwarded to the machine
//   grant[N]       one-hot registered grant
//   change_out[2N] per-slot change, gated by grant
//   beverage_out[N] per-slot beverage, gated by grant
//   busy           a grant is active
//   abandon        one-cycle pulse on timeout release
// -----------------------------------------------------------------------------
module vending_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15,
    parameter int TO_BITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [2*N-1:0]   coin_in,
    input  logic             vend_enable,
    input  logic             vend_beverage,
    input  logic [1:0]       vend_change,
    output logic [1:0]       deposit,
    output logic [N-1:0]     grant,
    output logic [2*N-1:0]   change_out,
    output logic [N-1:0]     beverage_out,
    output logic             busy,
    output logic             abandon
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(TIMEOUT);
    localparam logic [TO_BITS-1:0] TO_MAX   = {TO_BITS{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,   // no grant, waiting for requests
        S_ARMED  = 3'd1,   // granted, no coin accepted yet
        S_PAID   = 3'd2,   // at least one coin accepted, machine enabled
        S_SETTLE = 3'd3,   // machine busy returning change / beverage / refund
        S_DONE   = 3'd4    // final cycle so the last machine edge reaches the slot
    } state_t;

    state_t               state_reg, state_next;
    logic [N-1:0]         grant_reg, grant_next;
    logic [1:0]           deposit_reg, deposit_next;
    logic [PTR_W-1:0]     ptr_reg, ptr_next;
    logic [TO_BITS-1:0]   idle_cnt_reg, idle_cnt_next;
    logic                 abandon_reg, abandon_next;

    // -------------------------------------------------------------------------
    // Per-slot gating: coins of the granted slot only, and the machine's
    // change/beverage routed back only to the granted slot.
    // -------------------------------------------------------------------------
    logic [1:0] coin_masked [N];
    logic [1:0] granted_coin;
    logic       granted_req;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            assign coin_masked[gi]          = grant_reg[gi] ? coin_in[2*gi +: 2] : COIN_NONE;
            assign change_out[2*gi +: 2]    = grant_reg[gi] ? vend_change : COIN_NONE;
            assign beverage_out[gi]         = grant_reg[gi] & vend_beverage;
        end
    endgenerate

    // The grant is one-hot, so OR-ing the masked coins selects the granted one.
    always_comb begin
        granted_coin = COIN_NONE;
        for (int i = 0; i < N; i++) begin
            granted_coin = granted_coin | coin_masked[i];
        end
    end

    assign granted_req = |(req & grant_reg);

    // -------------------------------------------------------------------------
    // Round-robin search: first requester strictly after the pointer, wrapping.
    // A slot that drops req while another slot is served keeps its position,
    // because the pointer only moves when a grant is issued.
    // -------------------------------------------------------------------------
    logic             rr_found;
    logic [PTR_W-1:0] rr_win;
    logic [PTR_W:0]   rr_cand;

    always_comb begin
        rr_found = 1'b0;
        rr_win   = ptr_reg;
        rr_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            rr_cand = {1'b0, ptr_reg} + (PTR_W+1)'(k);
            if (rr_cand >= (PTR_W+1)'(N)) begin
                rr_cand = rr_cand - (PTR_W+1)'(N);
            end
            if (!rr_found && req[rr_cand[PTR_W-1:0]]) begin
                rr_found = 1'b1;
                rr_win   = rr_cand[PTR_W-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Idle counter increment, saturating so it can never wrap back below
    // TIMEOUT.
    // -------------------------------------------------------------------------
    logic [TO_BITS-1:0] idle_cnt_inc;
    assign idle_cnt_inc = (idle_cnt_reg == TO_MAX) ? idle_cnt_reg
                                                   : idle_cnt_reg + TO_BITS'(1);

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        ptr_next      = ptr_reg;
        idle_cnt_next = idle_cnt_reg;
        abandon_next  = 1'b0;
        deposit_next  = COIN_NONE;

        // A coin latched on the edge where enable falls is refunded by the
        // machine itself; nothing special is done for it here.
        if ((state_reg == S_ARMED || state_reg == S_PAID) && vend_enable) begin
            deposit_next = granted_coin;
        end

        case (state_reg)
            S_IDLE: begin
                if (rr_found) begin
                    grant_next = N'(1) << rr_win;
                    ptr_next   = rr_win;
                    state_next = S_ARMED;
                end
            end

            S_ARMED: begin
                if (!granted_req) begin
                    // Walked away before paying: silent release.
                    state_next   = S_IDLE;
                    grant_next   = '0;
                    deposit_next = COIN_NONE;
                end else if (vend_enable && granted_coin != COIN_NONE) begin
                    state_next    = S_PAID;
                    idle_cnt_next = '0;
                end
            end

            S_PAID: begin
                // req is deliberately ignored here: a paying customer cannot
                // release the machine by dropping req.
                if (!vend_enable) begin
                    state_next    = S_SETTLE;
                    idle_cnt_next = '0;
                end else if (granted_coin != COIN_NONE) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt_inc >= TO_LIMIT) begin
                    state_next    = S_IDLE;
                    grant_next    = '0;
                    abandon_next  = 1'b1;
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt_inc;
                end
            end

            S_SETTLE: begin
                if (vend_enable) begin
                    state_next = S_DONE;
                end
            end

            S_DONE: begin
                // Clearing here guarantees at least one IDLE cycle before the
                // next grant, so grants never overlap.
                grant_next = '0;
                state_next = S_IDLE;
            end

            default: begin
                grant_next    = '0;
                idle_cnt_next = '0;
                state_next    = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            grant_reg    <= '0;
            deposit_reg  <= COIN_NONE;
            ptr_reg      <= PTR_W'(N - 1);
            idle_cnt_reg <= '0;
            abandon_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            deposit_reg  <= deposit_next;
            ptr_reg      <= ptr_next;
            idle_cnt_reg <= idle_cnt_next;
            abandon_reg  <= abandon_next;
        end
    end

    assign grant   = grant_reg;
    assign deposit = deposit_reg;
    assign abandon = abandon_reg;
    assign busy    = |grant_reg;

endmodule

// File: tb/tb_vending_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vending_arbiter
//
// Directed bench for vending_arbiter (N=4, TIMEOUT=15). Inputs are driven 1 ns
// after each rising edge, and outputs are checked at that same point.
// Each check is an immediate assertion. Its failure branch counts the error
// and reports the tag, the observed value and the expected value.
// -----------------------------------------------------------------------------
module tb_vending_arbiter;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [2*N-1:0] coin_in;
    logic           vend_enable;
    logic           vend_beverage;
    logic [1:0]     vend_change;
    logic [1:0]     deposit;
    logic [N-1:0]   grant;
    logic [2*N-1:0] change_out;
    logic [N-1:0]   beverage_out;
    logic           busy;
    logic           abandon;

    int checks = 0;
    int errors = 0;

    vending_arbiter #(.N(N), .TIMEOUT(15), .TO_BITS(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .coin_in      (coin_in),
        .vend_enable  (vend_enable),
        .vend_beverage(vend_beverage),
        .vend_change  (vend_change),
        .deposit      (deposit),
        .grant        (grant),
        .change_out   (change_out),
        .beverage_out (beverage_out),
        .busy         (busy),
        .abandon      (abandon)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int         rr_slot [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;

    initial begin
        reset         = 1'b1;
        req           = '0;
        coin_in       = '0;
        vend_enable   = 1'b0;
        vend_beverage = 1'b1;
        vend_change   = 2'd3;
        tick();
        tick();

        // ---- reset state: routing must be gated even with machine activity
        chk("rst_grant",    32'(grant),        32'h0);
        chk("rst_deposit",  32'(deposit),      32'h0);
        chk("rst_busy",     32'(busy),         32'h0);
        chk("rst_abandon",  32'(abandon),      32'h0);
        chk("rst_change",   32'(change_out),   32'h0);
        chk("rst_beverage", 32'(beverage_out), 32'h0);
        vend_beverage = 1'b0;
        vend_change   = 2'd0;
        reset         = 1'b0;
        vend_enable   = 1'b1;
        tick();

        // ---- slot 1 buys with a quarter
        req = 4'b0010;
        tick();
        chk("s1_grant",   32'(grant),   32'h2);
        chk("s1_busy",    32'(busy),    32'h1);
        chk("s1_dep_pre", 32'(deposit), 32'h0);
        coin_in = 8'b0000_1100;
        tick();
        chk("s1_deposit", 32'(deposit), 32'h3);
        coin_in       = '0;
        vend_enable   = 1'b0;
        vend_beverage = 1'b1;
        #1;
        chk("s1_bev", 32'(beverage_out), 32'h2);
        tick();
        chk("s1_dep_none",    32'(deposit), 32'h0);
        chk("s1_grant_hold",  32'(grant),   32'h2);
        vend_beverage = 1'b0;
        vend_enable   = 1'b1;
        req           = '0;
        tick();
        chk("s1_grant_done", 32'(grant), 32'h2);
        tick();
        chk("s1_release", 32'(grant), 32'h0);
        $display("txn slot=1 quarter purchase complete");

        // ---- slot 0 abandons before paying; slot 1 pending gets it next
        req = 4'b0001;
        tick();
        chk("s0_grant", 32'(grant), 32'h1);
        req = 4'b0011;
        tick();
        chk("s0_hold", 32'(grant), 32'h1);
        req = 4'b0010;
        tick();
        chk("s0_release", 32'(grant),   32'h0);
        chk("s0_no_aband", 32'(abandon), 32'h0);
        tick();
        chk("s1_pending_grant", 32'(grant), 32'h2);
        req = '0;
        tick();
        chk("s1_drop_release", 32'(grant), 32'h0);
        $display("txn slot=0 abandoned before coin, slot=1 served then dropped");

        // ---- slot 2: dime, dime, quarter, then dime change and beverage
        req = 4'b0100;
        tick();
        chk("s2_grant", 32'(grant), 32'h4);
        coin_in = 8'b0010_0000;
        tick();
        chk("s2_dep_dime1", 32'(deposit), 32'h2);
        tick();
        chk("s2_dep_dime2", 32'(deposit), 32'h2);
        coin_in = 8'b0011_0000;
        tick();
        chk("s2_dep_quarter", 32'(deposit), 32'h3);
        coin_in     = '0;
        vend_enable = 1'b0;
        vend_change = 2'd2;
        #1;
        chk("s2_change",     32'(change_out),   32'h20);
        chk("s2_bev_none",   32'(beverage_out), 32'h0);
        tick();
        vend_change   = 2'd0;
        vend_beverage = 1'b1;
        #1;
        chk("s2_bev",        32'(beverage_out), 32'h4);
        chk("s2_change_off", 32'(change_out),   32'h0);
        tick();
        vend_beverage = 1'b0;
        vend_enable   = 1'b1;
        req           = '0;
        tick();
        tick();
        chk("s2_release", 32'(grant), 32'h0);
        $display("txn slot=2 45c purchase with dime change complete");

        // ---- slot 3: nickel then idle until the timeout releases it
        req = 4'b1000;
        tick();
        chk("s3_grant", 32'(grant), 32'h8);
        coin_in = 8'b0100_0000;
        tick();
        chk("s3_dep_nickel", 32'(deposit), 32'h1);
        coin_in = '0;
        for (int i = 0; i < 14; i++) tick();
        chk("s3_14idle_grant",   32'(grant),   32'h8);
        chk("s3_14idle_abandon", 32'(abandon), 32'h0);
        tick();
        chk("s3_to_abandon", 32'(abandon), 32'h1);
        chk("s3_to_grant",   32'(grant),   32'h0);
        req = '0;
        tick();
        chk("s3_abandon_pulse_end", 32'(abandon), 32'h0);
        $display("txn slot=3 timed out after nickel");

        // ---- all slots request continuously: grants rotate 0,1,2,3,0
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << rr_slot[i];
            tick();
            chk("rr_grant",  32'(grant),     32'(exp_g));
            chk("rr_onehot", 32'($onehot(grant)), 32'h1);
            coin_in = 8'(1) << (2 * rr_slot[i]);
            tick();
            coin_in     = '0;
            vend_enable = 1'b0;
            tick();
            vend_enable = 1'b1;
            tick();
            tick();
            chk("rr_gap_grant", 32'(grant), 32'h0);
            chk("rr_gap_busy",  32'(busy),  32'h0);
            $display("txn rr step=%0d slot=%0d served", i, rr_slot[i]);
        end

        // ---- reset while in SETTLE clears outputs immediately
        req = 4'b0100;
        tick();
        chk("rs_grant", 32'(grant), 32'h4);
        coin_in = 8'b0011_0000;
        tick();
        chk("rs_deposit", 32'(deposit), 32'h3);
        coin_in     = '0;
        vend_enable = 1'b0;
        tick();
        chk("rs_settle_grant", 32'(grant), 32'h4);
        reset = 1'b1;
        #1;
        chk("rs_async_grant",   32'(grant),   32'h0);
        chk("rs_async_deposit", 32'(deposit), 32'h0);
        chk("rs_async_busy",    32'(busy),    32'h0);
        tick();
        reset       = 1'b0;
        vend_enable = 1'b1;
        req         = 4'b1111;
        tick();
        chk("rs_first_grant", 32'(grant), 32'h1);
        $display("txn reset during settle, slot=0 granted first after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
